// File: rtl/skill_timer_unit_if.sv
// skill_timer_unit_if
// Bundles the skill request/response signals between the key front end
// (master) and the skill timer unit (slave).
//   req          : one-cycle request pulses, bit0 = J, bit1 = K, bit2 = L
//   grant        : one-cycle pulse, request i accepted
//   deny         : one-cycle pulse, request i rejected
//   skill_remain : skill i currently active
//   skill_point  : current skill-point count
interface skill_timer_unit_if;
  logic [2:0] req;
  logic [2:0] grant;
  logic [2:0] deny;
  logic [2:0] skill_remain;
  logic [1:0] skill_point;

  modport master (
    output req,
    input  grant, deny, skill_remain, skill_point
  );

  modport slave (
    input  req,
    output grant, deny, skill_remain, skill_point
  );
endinterface

// File: rtl/skill_timer_unit.sv
// skill_timer_unit
// Accepts or rejects J/K/L skill requests against the skill-point budget
// and each skill's activity, runs one duration timer per skill and refills
// skill points on a fixed period while the game stage is running.
// Ports:
//   clk_22 : game tick clock
//   rst    : asynchronous, active-high reset
//   enable : high while the game is in STAGE1; low clears timers/refill
//   bus    : slave side of skill_timer_unit_if (req in; grant, deny,
//            skill_remain, skill_point out)
module skill_timer_unit #(
  parameter int DUR_J         = 100,
  parameter int DUR_K         = 100,
  parameter int DUR_L         = 60,
  parameter int MAX_POINTS    = 3,
  parameter int REFILL_PERIOD = 200
) (
  input  logic              clk_22,
  input  logic              rst,
  input  logic              enable,
  skill_timer_unit_if.slave bus
);

  localparam logic [23:0] DUR_VEC   = {8'(DUR_L), 8'(DUR_K), 8'(DUR_J)};
  localparam logic [1:0]  MAX_PT    = 2'(MAX_POINTS);
  localparam logic [9:0]  RCNT_LAST = 10'(REFILL_PERIOD - 1);

  logic [2:0][7:0] tmr, tmr_next;
  logic [9:0]      rcnt, rcnt_next;
  logic [1:0]      point, point_next, point_refilled;
  logic [2:0]      grant_q, deny_q, grant_next, deny_next;
  logic [2:0]      idle, eligible;
  logic            refill;

  assign idle     = {tmr[2] == 8'd0, tmr[1] == 8'd0, tmr[0] == 8'd0};
  assign eligible = bus.req & idle & {3{point != 2'd0}};
  assign refill   = enable && (rcnt == RCNT_LAST);

  // Fixed-priority arbitration: lowest eligible index wins, every other
  // request seen this cycle (busy, no points, or lost) is denied.
  always_comb begin
    grant_next = 3'b000;
    deny_next  = 3'b000;
    if (enable) begin
      if (eligible[0])      grant_next = 3'b001;
      else if (eligible[1]) grant_next = 3'b010;
      else if (eligible[2]) grant_next = 3'b100;
      deny_next = bus.req & ~grant_next;
    end
  end

  // Timers: a grant loads the duration, otherwise a running timer counts
  // down; leaving the stage drops every timer to zero.
  always_comb begin
    tmr_next = '0;
    if (enable) begin
      for (int i = 0; i < 3; i++) begin
        if (grant_next[i])
          tmr_next[i] = DUR_VEC[i*8 +: 8];
        else if (!idle[i])
          tmr_next[i] = tmr[i] - 8'd1;
      end
    end
  end

  // Refill saturates first so that a refill at the ceiling is absorbed and
  // a simultaneous grant still costs a point. A grant implies point > 0,
  // so the subtraction cannot wrap.
  always_comb begin
    rcnt_next      = 10'd0;
    point_refilled = point;
    point_next     = point;
    if (enable) begin
      rcnt_next = refill ? 10'd0 : rcnt + 10'd1;
      if (refill && (point < MAX_PT))
        point_refilled = point + 2'd1;
      point_next = point_refilled - {1'b0, |grant_next};
    end
  end

  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      tmr     <= '0;
      rcnt    <= 10'd0;
      point   <= 2'd0;
      grant_q <= 3'b000;
      deny_q  <= 3'b000;
    end else begin
      tmr     <= tmr_next;
      rcnt    <= rcnt_next;
      point   <= point_next;
      grant_q <= grant_next;
      deny_q  <= deny_next;
    end
  end

  assign bus.grant        = grant_q;
  assign bus.deny         = deny_q;
  assign bus.skill_remain = ~idle;
  assign bus.skill_point  = point;

endmodule
